// File: rtl/reduce_seq_n.sv
// reduce_seq_n: multi-cycle reduction engine.
// Folds a WIDTH-bit vector CHUNK bits per clock into a one-bit AND/OR/XOR result. Setting
// op[2] inverts the result to give NAND/NOR/XNOR.
// Valid/ready interfaces are on both sides, and only one transaction is in flight at a time.
// Optional feature (define REDUCE_SEQ_EARLY_EXIT_EN): an AND/OR-family run stops once the
// accumulator reaches its dominating value.
module reduce_seq_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = $clog2(NCHUNK + 1);

  // Reject configurations that would silently drop bits.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_param_check
    $error("reduce_seq_n: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [2:0]        op_q, op_d;
  logic              acc_q, acc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              y_q, y_d;

  logic [CHUNK-1:0]  chunk;
  logic              acc_fold;
  logic              last_fold;
  logic              identity;

  // Fold the lowest chunk of the shift register into the accumulator.
  always_comb begin
    chunk = shift_q[CHUNK-1:0];
    case (op_q[1:0])
      2'b01:   acc_fold = acc_q | (|chunk);
      2'b10:   acc_fold = acc_q ^ (^chunk);
      default: acc_fold = acc_q & (&chunk);
    endcase
  end

  // Decide whether the current fold is the final one of the transaction.
  always_comb begin
    last_fold = (count_q == CntW'(NCHUNK - 1));
`ifdef REDUCE_SEQ_EARLY_EXIT_EN
    // AND-family saturates at 0 and OR-family at 1. XOR never saturates.
    if (op_q[1:0] == 2'b01) begin
      if (acc_fold) last_fold = 1'b1;
    end else if (op_q[1:0] != 2'b10) begin
      if (!acc_fold) last_fold = 1'b1;
    end
`endif
  end

  // Accumulator identity for the incoming op: 1 for the AND family, 0 for the others.
  always_comb begin
    identity = !((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
  end

  // Next-state logic for the control FSM and the datapath.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    op_d    = op_q;
    acc_d   = acc_q;
    count_d = count_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = a;
          op_d    = op;
          acc_d   = identity;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_fold;
        shift_d = shift_q >> CHUNK;
        count_d = count_q + CntW'(1);
        if (last_fold) begin
          // The result is registered here, so y stays put until the next completion.
          y_d     = acc_fold ^ op_q[2];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset discards any in-flight work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      op_q    <= '0;
      acc_q   <= 1'b0;
      count_q <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      y_q     <= y_d;
    end
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    y         = y_q;
  end

endmodule
